// File: rtl/reg_arb_pkg.sv
// Shared types and sizing helpers for the register-bank arbiter.
// Optional build macro used by the arbiter: REG_ARB_WR_PROTECT_EN.
package reg_arb_pkg;

   localparam int unsigned DEF_REG_W       = 8;
   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_TIMEOUT_CYC = 16;

   // Width of the WAIT counter; it must hold TIMEOUT_CYC-1.
   function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
      return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
   endfunction

   localparam int unsigned CNT_W = cnt_width(DEF_TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  wr_rdn;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_REG_W-1:0]  wdata;
   } req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int unsigned pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         pos = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register-bank port between NUM_REQ requesters.
// Optional REG_ARB_WR_PROTECT_EN: writes to the status region are refused locally.
module reg_bank_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned REG_W       = DEF_REG_W,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_wr_rdn,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*REG_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]        req_gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [REG_W-1:0]          rsp_rdata,
   output logic                      rsp_err,
   output logic                      bank_ena,
   output logic                      bank_wr_rdn,
   output logic [ADDR_W-1:0]         bank_addr,
   output logic [REG_W-1:0]          bank_wdata,
   output logic                      bank_we,
   input  logic [REG_W-1:0]          bank_rdata,
   input  logic                      bank_ack,
   input  logic                      bank_err
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYC);

   state_t             state, state_n;
   req_t               req_q, req_n;
   logic [IDX_W-1:0]   ptr, ptr_n, idx_q, idx_n, pick_idx;
   logic [NUM_REQ-1:0] pick_gnt, rsp_valid_n;
   logic               pick_any, prot_c;
   logic [TMO_W-1:0]   cnt, cnt_n;
   logic [REG_W-1:0]   rdata_n;
   logic               err_n, ena_n, we_n;
   int unsigned        sel_a, sel_d;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req (req_valid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant only in IDLE and never while reset is held.
   assign req_gnt = (state == IDLE && rstb) ? pick_gnt : '0;

   assign sel_a = 32'(pick_idx) * ADDR_W;
   assign sel_d = 32'(pick_idx) * REG_W;

`ifdef REG_ARB_WR_PROTECT_EN
   assign prot_c = req_wr_rdn[pick_idx] & req_addr[sel_a + ADDR_W - 1];
`else
   assign prot_c = 1'b0;
`endif

   always_comb begin
      state_n = state;
      req_n   = req_q;
      ptr_n   = ptr;
      idx_n   = idx_q;
      cnt_n   = cnt;
      rdata_n = '0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               req_n.wr_rdn = req_wr_rdn[pick_idx];
               req_n.addr   = req_addr[sel_a +: ADDR_W];
               req_n.wdata  = req_wdata[sel_d +: REG_W];
               idx_n        = pick_idx;
               ptr_n        = pick_idx;
               if (prot_c) begin
                  state_n = RESP;
                  err_n   = 1'b1;
               end else begin
                  state_n = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (bank_ack) begin
               state_n = RESP;
               rdata_n = req_q.wr_rdn ? '0 : bank_rdata;
               err_n   = bank_err;
            end else begin
               cnt_n   = '0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            // A late ack in the timeout cycle still wins.
            if (bank_ack) begin
               state_n = RESP;
               rdata_n = req_q.wr_rdn ? '0 : bank_rdata;
               err_n   = bank_err;
            end else if (cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
               state_n = RESP;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + TMO_W'(1);
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      ena_n       = (state_n == ISSUE) || (state_n == WAIT);
      we_n        = (state_n == ISSUE) && req_n.wr_rdn;
      rsp_valid_n = (state_n == RESP) ? (NUM_REQ'(1) << idx_n) : '0;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= IDLE;
         req_q     <= '0;
         ptr       <= IDX_W'(NUM_REQ - 1);
         idx_q     <= '0;
         cnt       <= '0;
         bank_ena  <= 1'b0;
         bank_we   <= 1'b0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         req_q     <= req_n;
         ptr       <= ptr_n;
         idx_q     <= idx_n;
         cnt       <= cnt_n;
         bank_ena  <= ena_n;
         bank_we   <= we_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rdata_n;
         rsp_err   <= err_n;
      end
   end

   assign bank_addr   = req_q.addr;
   assign bank_wdata  = req_q.wdata;
   assign bank_wr_rdn = req_q.wr_rdn;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (2 requesters, 8-bit).
module tb_reg_bank_arbiter;

   logic        clk = 1'b0;
   logic        rstb;
   logic [1:0]  req_valid, req_wr_rdn, req_gnt, rsp_valid;
   logic [15:0] req_addr, req_wdata;
   logic [7:0]  rsp_rdata, bank_addr, bank_wdata, bank_rdata;
   logic        rsp_err, bank_ena, bank_wr_rdn, bank_we, bank_ack, bank_err;

   int checks = 0;
   int errors = 0;

   reg_bank_arbiter dut (
      .clk        (clk),
      .rstb       (rstb),
      .req_valid  (req_valid),
      .req_wr_rdn (req_wr_rdn),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_gnt    (req_gnt),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bank_ena   (bank_ena),
      .bank_wr_rdn(bank_wr_rdn),
      .bank_addr  (bank_addr),
      .bank_wdata (bank_wdata),
      .bank_we    (bank_we),
      .bank_rdata (bank_rdata),
      .bank_ack   (bank_ack),
      .bank_err   (bank_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
      req_wr_rdn[i]      = wr;
      req_addr[i*8 +: 8]  = a;
      req_wdata[i*8 +: 8] = d;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},  32'(req_gnt),   32'h0);
      check({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rspd"}, 32'(rsp_rdata), 32'h0);
      check({tag, "_rspe"}, 32'(rsp_err),   32'h0);
      check({tag, "_ena"},  32'(bank_ena),  32'h0);
      check({tag, "_we"},   32'(bank_we),   32'h0);
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      repeat (2) tick();
      rstb = 1'b1;
   endtask

   initial begin
      logic [1:0] e;
      rstb       = 1'b0;
      req_valid  = 2'b11;
      req_wr_rdn = '0;
      req_addr   = '0;
      req_wdata  = '0;
      bank_rdata = '0;
      bank_ack   = 1'b1;
      bank_err   = 1'b0;

      // Reset state, with requests present.
      repeat (2) tick();
      check_all_zero("reset");
      check("reset_addr", 32'(bank_addr), 32'h0);
      req_valid = '0;
      rstb      = 1'b1;
      tick();

      // Single write from requester 0 to an always-acking bank.
      set_req(0, 1'b1, 8'h03, 8'hA5);
      req_valid = 2'b01;
      #1 check("wr_gnt", 32'(req_gnt), 32'h1);
      tick();
      req_valid = '0;
      check("wr_we", 32'(bank_we), 32'h1);
      check("wr_ena", 32'(bank_ena), 32'h1);
      check("wr_addr", 32'(bank_addr), 32'h03);
      check("wr_data", 32'(bank_wdata), 32'hA5);
      check("wr_rspv_early", 32'(rsp_valid), 32'h0);
      tick();
      check("wr_rspv", 32'(rsp_valid), 32'h1);
      check("wr_err", 32'(rsp_err), 32'h0);
      check("wr_rdata", 32'(rsp_rdata), 32'h0);
      check("wr_we_off", 32'(bank_we), 32'h0);
      tick();
      check("wr_rspv_done", 32'(rsp_valid), 32'h0);

      // Fairness: both requesters valid, six reads.
      do_reset();
      set_req(0, 1'b0, 8'h11, 8'h00);
      set_req(1, 1'b0, 8'h22, 8'h00);
      req_valid = 2'b11;
      for (int g = 0; g < 6; g++) begin
         e = (g % 2 == 0) ? 2'b01 : 2'b10;
         bank_rdata = 8'h10 + 8'(g);
         #1 check("rr_gnt", 32'(req_gnt), 32'(e));
         tick();
         check("rr_gnt_issue", 32'(req_gnt), 32'h0);
         check("rr_addr", 32'(bank_addr), (g % 2 == 0) ? 32'h11 : 32'h22);
         check("rr_we", 32'(bank_we), 32'h0);
         tick();
         check("rr_rspv", 32'(rsp_valid), 32'(e));
         check("rr_rdata", 32'(rsp_rdata), 32'h10 + 32'(g));
         check("rr_gnt_resp", 32'(req_gnt), 32'h0);
         tick();
         check("rr_rspv_one", 32'(rsp_valid), 32'h0);
      end
      req_valid = '0;
      tick();

      // Status-region read: data captured, cleared after RESP.
      set_req(0, 1'b0, 8'h82, 8'h00);
      bank_rdata = 8'h3C;
      req_valid  = 2'b01;
      tick();
      req_valid = '0;
      check("rd82_addr", 32'(bank_addr), 32'h82);
      tick();
      check("rd82_rspv", 32'(rsp_valid), 32'h1);
      check("rd82_rdata", 32'(rsp_rdata), 32'h3C);
      tick();
      check("rd82_rdata_clr", 32'(rsp_rdata), 32'h0);

      // Timeout: bank never acks; requester 1 wins (last grant was 0).
      bank_ack   = 1'b0;
      bank_rdata = 8'h5A;
      set_req(1, 1'b0, 8'h44, 8'h00);
      req_valid = 2'b11;
      #1 check("to_gnt", 32'(req_gnt), 32'h2);
      tick();
      check("to_issue_ena", 32'(bank_ena), 32'h1);
      for (int w = 0; w < 16; w++) begin
         tick();
         check("to_wait_ena", 32'(bank_ena), 32'h1);
         check("to_wait_rspv", 32'(rsp_valid), 32'h0);
      end
      tick();
      check("to_rspv", 32'(rsp_valid), 32'h2);
      check("to_err", 32'(rsp_err), 32'h1);
      check("to_rdata", 32'(rsp_rdata), 32'h0);
      tick();
      check("to_next_gnt", 32'(req_gnt), 32'h1);

      // Reset in the middle of WAIT.
      tick();
      tick();
      tick();
      check("rst_in_wait", 32'(bank_ena), 32'h1);
      req_valid = '0;
      #2 rstb = 1'b0;
      #1 check_all_zero("rst_async");
      bank_ack = 1'b1;
      tick();
      tick();
      rstb = 1'b1;
      tick();
      check("rst_no_rsp0", 32'(rsp_valid), 32'h0);
      tick();
      check("rst_no_rsp1", 32'(rsp_valid), 32'h0);
      req_valid = 2'b11;
      #1 check("rst_first_gnt", 32'(req_gnt), 32'h1);

      // Write into the status region, bank reporting an error.
      req_valid = 2'b01;
      set_req(0, 1'b1, 8'h81, 8'h77);
      bank_err = 1'b1;
      tick();
      req_valid = '0;
`ifdef REG_ARB_WR_PROTECT_EN
      check("wp_we", 32'(bank_we), 32'h0);
      check("wp_ena", 32'(bank_ena), 32'h0);
      check("wp_rspv", 32'(rsp_valid), 32'h1);
      check("wp_err", 32'(rsp_err), 32'h1);
      check("wp_rdata", 32'(rsp_rdata), 32'h0);
      tick();
      check("wp_we_after", 32'(bank_we), 32'h0);
      check("wp_rspv_after", 32'(rsp_valid), 32'h0);
`else
      check("wp_we", 32'(bank_we), 32'h1);
      check("wp_addr", 32'(bank_addr), 32'h81);
      tick();
      check("wp_rspv", 32'(rsp_valid), 32'h1);
      check("wp_err", 32'(rsp_err), 32'h1);
      check("wp_rdata", 32'(rsp_rdata), 32'h0);
`endif
      bank_err = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
